// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared pipeline/buffer package.
// Holds the data-memory request bundle and the read-owner tag used by the
// data-memory port arbiter.
//   dm_owner_e : which requester owned the read issued last cycle
//   dm_req_t   : one data-memory access (core side, ext side, memory side)
package Pipe_Buf_Reg_PKG;

  localparam int unsigned DM_DATA_W = 32;
  localparam int unsigned DM_ADDR_W = 9;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } dm_owner_e;

  typedef struct packed {
    logic                 rd;
    logic                 wr;
    logic [DM_ADDR_W-1:0] addr;
    logic [DM_DATA_W-1:0] wdata;
    logic [2:0]           func3;
  } dm_req_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating starvation counter for the external data-memory requester.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : clear counter (has priority over inc)
//   inc        : count one more waiting cycle
//   starve     : counter has reached STARVE_LIMIT
module dmem_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic starve
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;

  assign starve = (cnt >= LIMIT);

  // Holding at LIMIT keeps cnt from ever wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !starve) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the MEM stage (core) and an external
// loader/debug port (ext). The core has priority; ext takes idle cycles,
// every cycle while halted, and is force-granted (stalling the core for one
// cycle) after waiting STARVE_LIMIT cycles. Read data returns one cycle
// after the access, tagged to the requester that owned it.
//   clk, reset          : clock, asynchronous active-low reset
//   core_*              : MEM-stage access; core_stall freezes the front pipe
//   core_rdata          : load data to MEM/WB (always mem_rdata)
//   halted              : processor halted, ext may use every cycle
//   ext_req/we/addr/... : ext access, held until ext_gnt
//   ext_rvalid/rdata    : ext read return, one cycle after the grant
//   mem_*               : data-memory side
module dmem_port_arbiter
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DM_ADDRESS   = 9,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic                  core_stall,
  output logic [DATA_W-1:0]     core_rdata,
  input  logic                  halted,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [DM_ADDRESS-1:0] ext_addr,
  input  logic [DATA_W-1:0]     ext_wdata,
  input  logic [2:0]            ext_func3,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_W-1:0]     ext_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  // The request bundle is a fixed-width package type.
  if (DATA_W != DM_DATA_W || DM_ADDRESS != DM_ADDR_W) begin : g_bad_width
    $error("dmem_port_arbiter: DATA_W/DM_ADDRESS must match Pipe_Buf_Reg_PKG");
  end
  if ((64'd1 << CNT_W) <= 64'(STARVE_LIMIT)) begin : g_bad_cnt_w
    $error("dmem_port_arbiter: CNT_W too small for STARVE_LIMIT");
  end

  dm_req_t   core_req;
  dm_req_t   ext_side;
  dm_req_t   mem_req;
  dm_owner_e rd_owner;
  logic      core_act;
  logic      starve;

  dmem_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr   (ext_gnt | ~ext_req),
    .inc   (ext_req & ~ext_gnt),
    .starve(starve)
  );

  always_comb begin
    core_act = core_rd | core_wr;
    core_req = '{rd: core_rd, wr: core_wr, addr: core_addr,
                 wdata: core_wdata, func3: core_func3};
    ext_side = '{rd: ~ext_we, wr: ext_we, addr: ext_addr,
                 wdata: ext_wdata, func3: ext_func3};

    // Reset also blocks strobes combinationally so nothing reaches memory
    // while reset is held, even with live MEM-stage inputs.
    ext_gnt    = reset & ext_req & (halted | ~core_act | starve);
    core_stall = core_act & ext_gnt;

    mem_req = core_req;
    if (!reset) begin
      mem_req.rd = 1'b0;
      mem_req.wr = 1'b0;
    end
    if (ext_gnt) begin
      mem_req = ext_side;
    end
  end

  assign mem_rd    = mem_req.rd;
  assign mem_wr    = mem_req.wr;
  assign mem_addr  = mem_req.addr;
  assign mem_wdata = mem_req.wdata;
  assign mem_func3 = mem_req.func3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_owner <= OWN_NONE;
    end else if (mem_req.rd) begin
      rd_owner <= ext_gnt ? OWN_EXT : OWN_CORE;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  assign ext_rvalid = (rd_owner == OWN_EXT);
  assign ext_rdata  = ext_rvalid ? mem_rdata : '0;
  assign core_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_rd, core_wr;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic [2:0]  core_func3;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        halted;
  logic        ext_req, ext_we;
  logic [8:0]  ext_addr;
  logic [31:0] ext_wdata;
  logic [2:0]  ext_func3;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .DATA_W      (32),
    .DM_ADDRESS  (9),
    .STARVE_LIMIT(8),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .core_rd   (core_rd),
    .core_wr   (core_wr),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_func3(core_func3),
    .core_stall(core_stall),
    .core_rdata(core_rdata),
    .halted    (halted),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_func3 (ext_func3),
    .ext_gnt   (ext_gnt),
    .ext_rvalid(ext_rvalid),
    .ext_rdata (ext_rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_func3 (mem_func3),
    .mem_rdata (mem_rdata)
  );

  // Word-wide data memory with one-cycle read latency.
  logic [31:0] mem [0:127];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[8:2]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[8:2]];
  end

  task automatic idle_inputs;
    core_rd = 0; core_wr = 0; core_addr = '0; core_wdata = '0; core_func3 = 3'b010;
    halted = 0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_func3 = 3'b010;
  endtask

  task automatic test_reset;
    // store a known word at 0x010 with the core idle
    @(negedge clk);
    ext_req = 1; ext_we = 1; ext_addr = 9'h010; ext_wdata = 32'hCAFE_0010;
    #1;
    tests_run++;
    if (ext_gnt !== 1'b1) begin
      tests_failed++; $display("FAIL preload_gnt: got %b want 1", ext_gnt);
    end
    // core busy, ext read waiting for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ext_req = 1; ext_we = 0; ext_addr = 9'h010; core_rd = 1; core_addr = 9'h040;
    end
    @(negedge clk);
    tests_run++;
    if (dut.u_starve.cnt !== 4'd5) begin
      tests_failed++; $display("FAIL pre_reset_cnt: got %0d want 5", dut.u_starve.cnt);
    end
    #3 reset = 0;
    #1;
    tests_run++;
    if ({ext_gnt, core_stall, ext_rvalid, mem_rd, mem_wr} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got gnt=%b stall=%b rvalid=%b rd=%b wr=%b want all 0",
               ext_gnt, core_stall, ext_rvalid, mem_rd, mem_wr);
    end
    tests_run++;
    if (dut.u_starve.cnt !== 4'd0) begin
      tests_failed++; $display("FAIL reset_cnt: got %0d want 0", dut.u_starve.cnt);
    end
    @(negedge clk);
    reset = 1;
    core_rd = 0; core_addr = '0;
    ext_req = 1; ext_we = 0; ext_addr = 9'h010;
    #1;
    tests_run++;
    if (ext_gnt !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 9'h010) begin
      tests_failed++;
      $display("FAIL post_reset_gnt: got gnt=%b rd=%b addr=%h want 1 1 010",
               ext_gnt, mem_rd, mem_addr);
    end
    @(negedge clk);
    ext_req = 0;
    #1;
    tests_run++;
    if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hCAFE_0010) begin
      tests_failed++;
      $display("FAIL post_reset_rdata: got rvalid=%b data=%h want 1 cafe0010",
               ext_rvalid, ext_rdata);
    end
  endtask

  task automatic test_starvation;
    logic prev_stall;
    prev_stall = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      core_rd = 1; core_addr = 9'h020;
      ext_req = 1; ext_we = 0; ext_addr = 9'h030;
      #1;
      tests_run++;
      if (ext_gnt !== (c == 9) || core_stall !== (c == 9)) begin
        tests_failed++;
        $display("FAIL starve_c%0d: got gnt=%b stall=%b want %b %b",
                 c, ext_gnt, core_stall, (c == 9), (c == 9));
      end
      tests_run++;
      if (prev_stall && core_stall) begin
        tests_failed++; $display("FAIL double_stall_c%0d: got stall=1 twice want not", c);
      end
      prev_stall = core_stall;
      if (c == 9) begin
        tests_run++;
        if (mem_addr !== 9'h030 || mem_rd !== 1'b1) begin
          tests_failed++; $display("FAIL force_addr: got %h want 030", mem_addr);
        end
      end
      if (c == 10) begin
        tests_run++;
        if (mem_addr !== 9'h020 || mem_rd !== 1'b1 || ext_rvalid !== 1'b1) begin
          tests_failed++;
          $display("FAIL replay: got addr=%h rd=%b rvalid=%b want 020 1 1",
                   mem_addr, mem_rd, ext_rvalid);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    logic [8:0] a;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      a = 9'(i * 4);
      ext_req = 1; ext_we = 1; ext_addr = a; ext_wdata = 32'h1111_0000 + i;
      #1;
      tests_run++;
      if (ext_gnt !== 1'b1 || core_stall !== 1'b0 || mem_wr !== 1'b1 || mem_addr !== a) begin
        tests_failed++;
        $display("FAIL b2b_w%0d: got gnt=%b stall=%b wr=%b addr=%h want 1 0 1 %h",
                 i, ext_gnt, core_stall, mem_wr, mem_addr, a);
      end
    end
    @(negedge clk);
    ext_req = 0; ext_we = 0; core_rd = 1; core_addr = 9'h008;
    #1;
    tests_run++;
    if (mem_rd !== 1'b1 || mem_addr !== 9'h008 || ext_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_lw_issue: got rd=%b addr=%h gnt=%b want 1 008 0", mem_rd, mem_addr, ext_gnt);
    end
    @(negedge clk);
    core_rd = 0;
    #1;
    tests_run++;
    if (core_rdata !== 32'h1111_0002 || ext_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_lw_data: got data=%h rvalid=%b want 11110002 0", core_rdata, ext_rvalid);
    end
  endtask

  task automatic test_halted;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      halted = 1; core_rd = 1; core_addr = 9'h040;
      ext_req = 1; ext_we = 0; ext_addr = 9'h004;
      #1;
      tests_run++;
      if (ext_gnt !== 1'b1 || core_stall !== 1'b1) begin
        tests_failed++;
        $display("FAIL halted_c%0d: got gnt=%b stall=%b want 1 1", c, ext_gnt, core_stall);
      end
      if (c > 1) begin
        tests_run++;
        if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h1111_0001) begin
          tests_failed++;
          $display("FAIL halted_rd_c%0d: got rvalid=%b data=%h want 1 11110001",
                   c, ext_rvalid, ext_rdata);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_rvalid_timing;
    @(negedge clk);
    ext_req = 1; ext_we = 0; ext_addr = 9'h00C;
    #1;
    tests_run++;
    if (ext_gnt !== 1'b1) begin
      tests_failed++; $display("FAIL rv_gnt_N: got %b want 1", ext_gnt);
    end
    @(negedge clk);
    ext_req = 0; core_rd = 1; core_addr = 9'h000;
    #1;
    tests_run++;
    if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h1111_0003 || ext_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL rv_N1: got rvalid=%b data=%h gnt=%b want 1 11110003 0",
               ext_rvalid, ext_rdata, ext_gnt);
    end
    @(negedge clk);
    core_rd = 0;
    #1;
    tests_run++;
    if (ext_rvalid !== 1'b0 || ext_rdata !== 32'h0 || core_rdata !== 32'h1111_0000) begin
      tests_failed++;
      $display("FAIL rv_N2: got rvalid=%b edata=%h cdata=%h want 0 0 11110000",
               ext_rvalid, ext_rdata, core_rdata);
    end
  endtask

  task automatic test_req_drop;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      core_rd = 1; core_addr = 9'h050;
      ext_req = 1; ext_we = 1; ext_addr = 9'h060; ext_wdata = 32'hDEAD_BEEF;
      #1;
      tests_run++;
      if (ext_gnt !== 1'b0 || core_stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL drop_c%0d: got gnt=%b stall=%b want 0 0", c, ext_gnt, core_stall);
      end
    end
    @(negedge clk);
    ext_req = 0;
    #1;
    tests_run++;
    if (ext_gnt !== 1'b0 || mem_wr !== 1'b0) begin
      tests_failed++; $display("FAIL drop_gap: got gnt=%b wr=%b want 0 0", ext_gnt, mem_wr);
    end
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      ext_req = 1;
      #1;
      tests_run++;
      if (ext_gnt !== (c == 9)) begin
        tests_failed++;
        $display("FAIL drop_rewait_c%0d: got gnt=%b want %b", c, ext_gnt, (c == 9));
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    tests_run++;
    if (mem[9'h060 >> 2] !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL drop_write: got %h want deadbeef", mem[9'h060 >> 2]);
    end
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1;
    test_reset();
    @(negedge clk);
    idle_inputs();
    test_starvation();
    test_back_to_back();
    @(negedge clk);
    idle_inputs();
    test_halted();
    test_rvalid_timing();
    test_req_drop();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
